// File: rtl/score_display_scheduler.sv
// Shares the 4-digit seven-segment driver between the BCD-converted game score and
// timed, optionally blinking game messages with preemption.
module score_display_scheduler #(
    parameter int unsigned HOLD_CYCLES  = 100000000,
    parameter int unsigned BLINK_CYCLES = 25000000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] score,
    input  logic        score_update,
    input  logic        msg_req,
    input  logic [15:0] msg_val,
    input  logic        msg_blink,
    output logic        msg_ack,
    output logic [15:0] big_bin,
    output logic        blank,
    output logic        busy,
    output logic        msg_active
);

    localparam logic [0:0] StShowScore = 1'b0;
    localparam logic [0:0] StShowMsg   = 1'b1;

    localparam logic [CNT_W-1:0] HoldLoad  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BlinkLoad = CNT_W'(BLINK_CYCLES - 1);

    // Double-dabble conversion state
    logic        busy_q, busy_d;
    logic        pending_q, pending_d;
    logic [3:0]  iter_q, iter_d;
    logic [15:0] sat_q, sat_d;
    logic [15:0] work_q, work_d;
    logic [15:0] bcd_q, bcd_d;
    logic [15:0] adj;

    // Display arbitration state
    logic [0:0]       state_q, state_d;
    logic [15:0]      msg_q, msg_d;
    logic             blink_q, blink_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             ack_q, ack_d;
    logic [15:0]      big_bin_q, big_bin_d;

    always_comb begin
        adj = work_q;
        for (int i = 0; i < 4; i++) begin
            if (work_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = work_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        busy_d    = busy_q;
        pending_d = pending_q;
        iter_d    = iter_q;
        sat_d     = sat_q;
        work_d    = work_q;
        bcd_d     = bcd_q;
        if (busy_q) begin
            if (score_update) begin
                pending_d = 1'b1;
            end
            work_d = {adj[14:0], sat_q[15]};
            sat_d  = {sat_q[14:0], 1'b0};
            iter_d = iter_q + 4'd1;
            if (iter_q == 4'd15) begin
                bcd_d  = {adj[14:0], sat_q[15]};
                busy_d = 1'b0;
            end
        end else if (score_update || pending_q) begin
            sat_d     = (score > 16'd9999) ? 16'd9999 : score;
            work_d    = '0;
            iter_d    = '0;
            busy_d    = 1'b1;
            pending_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        blink_d   = blink_q;
        phase_d   = phase_q;
        hold_d    = hold_q;
        bcnt_d    = bcnt_q;
        ack_d     = msg_req;
        big_bin_d = (state_q == StShowMsg) ? msg_q : bcd_q;
        // A request is accepted in either state and wins over expiry.
        if (msg_req) begin
            state_d = StShowMsg;
            msg_d   = msg_val;
            blink_d = msg_blink;
            phase_d = 1'b0;
            hold_d  = HoldLoad;
            bcnt_d  = BlinkLoad;
        end else if (state_q == StShowMsg) begin
            if (hold_q == '0) begin
                state_d = StShowScore;
            end else begin
                hold_d = hold_q - 1'b1;
            end
            if (bcnt_q == '0) begin
                bcnt_d  = BlinkLoad;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            iter_q    <= '0;
            sat_q     <= '0;
            work_q    <= '0;
            bcd_q     <= '0;
            state_q   <= StShowScore;
            msg_q     <= '0;
            blink_q   <= 1'b0;
            phase_q   <= 1'b0;
            hold_q    <= '0;
            bcnt_q    <= '0;
            ack_q     <= 1'b0;
            big_bin_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
            iter_q    <= iter_d;
            sat_q     <= sat_d;
            work_q    <= work_d;
            bcd_q     <= bcd_d;
            state_q   <= state_d;
            msg_q     <= msg_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            bcnt_q    <= bcnt_d;
            ack_q     <= ack_d;
            big_bin_q <= big_bin_d;
        end
    end

    assign busy       = busy_q;
    assign msg_ack    = ack_q;
    assign big_bin    = big_bin_q;
    assign msg_active = (state_q == StShowMsg);
    assign blank      = msg_active & blink_q & phase_q;

endmodule

// File: tb/tb_score_display_scheduler.sv
// Bench for score_display_scheduler: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_score_display_scheduler;

    localparam int HOLD  = 8;
    localparam int BLINK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] score = '0;
    logic        score_update = 1'b0;
    logic        msg_req = 1'b0;
    logic [15:0] msg_val = '0;
    logic        msg_blink = 1'b0;
    logic        msg_ack;
    logic [15:0] big_bin;
    logic        blank;
    logic        busy;
    logic        msg_active;

    int n_checks = 0;
    int n_fail   = 0;

    score_display_scheduler #(
        .HOLD_CYCLES (HOLD),
        .BLINK_CYCLES(BLINK),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .score       (score),
        .score_update(score_update),
        .msg_req     (msg_req),
        .msg_val     (msg_val),
        .msg_blink   (msg_blink),
        .msg_ack     (msg_ack),
        .big_bin     (big_bin),
        .blank       (blank),
        .busy        (busy),
        .msg_active  (msg_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Reference model: conversions and messages tracked by start timestamps.
    int          e = 0;
    bit          m_busy, m_pending, m_show, m_mblink, m_ack, m_blank;
    int          m_end, m_val, m_start;
    logic [15:0] m_bcd, m_mval, m_big;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_pending = 0; m_show = 0; m_mblink = 0; m_ack = 0; m_blank = 0;
            m_bcd = '0; m_mval = '0; m_big = '0;
        end else begin
            e++;
            m_big = m_show ? m_mval : m_bcd;
            if (m_busy) begin
                if (score_update) m_pending = 1;
                if (e == m_end) begin
                    m_bcd  = to_bcd(m_val);
                    m_busy = 0;
                end
            end else if (score_update || m_pending) begin
                m_val     = (int'(score) > 9999) ? 9999 : int'(score);
                m_end     = e + 16;
                m_busy    = 1;
                m_pending = 0;
            end
            m_ack = msg_req;
            if (msg_req) begin
                m_show = 1; m_start = e; m_mval = msg_val; m_mblink = msg_blink;
            end else if (m_show && (e - m_start) >= HOLD) begin
                m_show = 0;
            end
            m_blank = m_show && m_mblink && (((e - m_start) / BLINK) % 2 == 1);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_big_bin", 32'(big_bin), 32'(m_big));
            check("model_blank", 32'(blank), 32'(m_blank));
            check("model_msg_active", 32'(msg_active), 32'(m_show));
            check("model_msg_ack", 32'(msg_ack), 32'(m_ack));
        end
    end

    task automatic send_msg(input logic [15:0] v, input logic b);
        msg_val = v; msg_blink = b; msg_req = 1'b1;
        @(negedge clk);
        msg_req = 1'b0;
    endtask

    initial begin
        int n, acks, hits, act, rises;
        bit prev;
        logic [7:0] blank_seq;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_big_bin", 32'(big_bin), 32'h0000);
        check("reset_busy", 32'(busy), 32'h0);

        // Conversion of 1234 and busy length
        score = 16'd1234; score_update = 1'b1;
        @(negedge clk);
        score_update = 1'b0;
        n = 0;
        while (busy && n < 40) begin n++; @(negedge clk); end
        check("busy_length", 32'(n), 32'd16);
        @(negedge clk);
        check("bcd_1234", 32'(big_bin), 32'h1234);

        // Saturation
        score = 16'd12000; score_update = 1'b1;
        @(negedge clk);
        score_update = 1'b0;
        repeat (20) @(negedge clk);
        check("bcd_sat_9999", 32'(big_bin), 32'h9999);

        score = 16'd1234; score_update = 1'b1;
        @(negedge clk);
        score_update = 1'b0;
        repeat (20) @(negedge clk);
        check("bcd_1234_again", 32'(big_bin), 32'h1234);

        // Plain message, 8 cycles on display
        send_msg(16'hC1EA, 1'b0);
        check("msg_ack_pulse", 32'(msg_ack), 32'h1);
        acks = 0; hits = 0; act = 0;
        for (int i = 0; i < 12; i++) begin
            acks += int'(msg_ack);
            hits += int'(big_bin == 16'hC1EA);
            act  += int'(msg_active);
            @(negedge clk);
        end
        check("msg_ack_count", 32'(acks), 32'd1);
        check("msg_display_cycles", 32'(hits), 32'd8);
        check("msg_active_cycles", 32'(act), 32'd8);
        check("msg_return_score", 32'(big_bin), 32'h1234);
        check("msg_return_inactive", 32'(msg_active), 32'h0);

        // Blinking message
        send_msg(16'h0003, 1'b1);
        for (int i = 0; i < 8; i++) begin
            blank_seq[7-i] = blank;
            @(negedge clk);
        end
        check("blink_sequence", 32'(blank_seq), 32'b00110011);
        check("blink_blank_after", 32'(blank), 32'h0);
        repeat (2) @(negedge clk);

        // Pulses while busy collapse into one restart
        prev = busy; rises = 0;
        score = 16'd5; score_update = 1'b1;
        for (int i = 0; i < 48; i++) begin
            if (i == 1) score_update = 1'b0;
            if (i == 4) begin score = 16'd42; score_update = 1'b1; end
            if (i == 5) score_update = 1'b0;
            @(negedge clk);
            if (busy && !prev) rises++;
            prev = busy;
        end
        check("busy_starts", 32'(rises), 32'd2);
        check("bcd_0042", 32'(big_bin), 32'h0042);

        // Preemption on the expiry cycle
        send_msg(16'hC1EA, 1'b0);
        repeat (7) @(negedge clk);
        send_msg(16'hAAAA, 1'b0);
        check("preempt_ack", 32'(msg_ack), 32'h1);
        check("preempt_active", 32'(msg_active), 32'h1);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            hits += int'(big_bin == 16'hAAAA);
            @(negedge clk);
        end
        check("preempt_display_cycles", 32'(hits), 32'd8);

        // Asynchronous reset during a message
        score = 16'd777; score_update = 1'b1;
        @(negedge clk);
        score_update = 1'b0;
        send_msg(16'h5A5A, 1'b1);
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_big_bin", 32'(big_bin), 32'h0000);
        check("arst_blank", 32'(blank), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_msg_ack", 32'(msg_ack), 32'h0);
        check("arst_msg_active", 32'(msg_active), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acks = 0; act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acks += int'(msg_ack);
            act  += int'(msg_active) + int'(busy);
        end
        check("post_reset_no_ack", 32'(acks), 32'd0);
        check("post_reset_idle", 32'(act), 32'd0);
        check("post_reset_big_bin", 32'(big_bin), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
